// File: rtl/active_list.sv
// Active list: in-order retirement tracker for the out-of-order MIPS core.
// Dispatch allocates entries at the tail, execution units mark entries done
// by index, and completed entries retire strictly in order from the head.
// Optional build macro ACTIVE_LIST_EXCEPTION_EN adds a per-entry exception
// bit; committing an excepting head discards every in-flight entry.
module active_list #(
   parameter int DEPTH = 32,
   parameter int IDX_W = 5,
   parameter int PC_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               alloc_valid,
   output logic               alloc_ready,
   input  logic [4:0]         alloc_dest_reg,
   input  logic [PC_W-1:0]    alloc_pc,
   output logic [IDX_W-1:0]   alloc_index,
   input  logic               complete_valid,
   input  logic [IDX_W-1:0]   complete_index,
`ifdef ACTIVE_LIST_EXCEPTION_EN
   input  logic               complete_exception,
   output logic               commit_exception,
`endif
   output logic               commit_valid,
   input  logic               commit_ready,
   output logic [IDX_W-1:0]   commit_index,
   output logic [4:0]         commit_dest_reg,
   output logic [PC_W-1:0]    commit_pc,
   input  logic               flush,
   output logic [IDX_W:0]     count,
   output logic               empty,
   output logic               full
);

   localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [IDX_W:0]     head_r;
   logic [IDX_W:0]     tail_r;
   logic [DEPTH-1:0]   valid_r;
   logic [DEPTH-1:0]   done_r;
   logic [4:0]         dest_r [DEPTH];
   logic [PC_W-1:0]    pc_r   [DEPTH];
`ifdef ACTIVE_LIST_EXCEPTION_EN
   logic [DEPTH-1:0]   exc_r;
`endif

   logic [IDX_W-1:0]   head_idx_s;
   logic [IDX_W-1:0]   tail_idx_s;
   logic               full_s;
   logic               empty_s;
   logic               commit_valid_s;
   logic               alloc_fire_s;
   logic               commit_fire_s;
   logic               exc_flush_s;
   logic               clear_s;

   // Derive status and handshake fire conditions from registered state only.
   always_comb begin
      head_idx_s     = head_r[IDX_W-1:0];
      tail_idx_s     = tail_r[IDX_W-1:0];
      full_s         = (head_idx_s == tail_idx_s) && (head_r[IDX_W] != tail_r[IDX_W]);
      empty_s        = (head_r == tail_r);
      commit_valid_s = !empty_s && done_r[head_idx_s];
      // Slot freed by a same-cycle commit is not reusable until next cycle.
      alloc_fire_s   = alloc_valid && !full_s;
      commit_fire_s  = commit_valid_s && commit_ready;
`ifdef ACTIVE_LIST_EXCEPTION_EN
      exc_flush_s    = commit_fire_s && exc_r[head_idx_s];
`else
      exc_flush_s    = 1'b0;
`endif
      clear_s        = flush || exc_flush_s;
   end

   assign alloc_ready     = !full_s;
   assign alloc_index     = tail_idx_s;
   assign commit_valid    = commit_valid_s;
   assign commit_index    = head_idx_s;
   assign commit_dest_reg = dest_r[head_idx_s];
   assign commit_pc       = pc_r[head_idx_s];
   assign count           = tail_r - head_r;
   assign empty           = empty_s;
   assign full            = full_s;
`ifdef ACTIVE_LIST_EXCEPTION_EN
   assign commit_exception = commit_valid_s && exc_r[head_idx_s];
`endif

   // Pointer and per-entry status update; later assignments take priority
   // (commit clears over completion, allocate initialises the tail slot).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= '0;
         tail_r  <= '0;
         valid_r <= '0;
         done_r  <= '0;
`ifdef ACTIVE_LIST_EXCEPTION_EN
         exc_r   <= '0;
`endif
      end else if (clear_s) begin
         head_r  <= '0;
         tail_r  <= '0;
         valid_r <= '0;
         done_r  <= '0;
`ifdef ACTIVE_LIST_EXCEPTION_EN
         exc_r   <= '0;
`endif
      end else begin
         // Completion of an unallocated slot is dropped; repeats are harmless.
         if (complete_valid && valid_r[complete_index]) begin
            done_r[complete_index] <= 1'b1;
`ifdef ACTIVE_LIST_EXCEPTION_EN
            exc_r[complete_index]  <= exc_r[complete_index] | complete_exception;
`endif
         end
         if (commit_fire_s) begin
            valid_r[head_idx_s] <= 1'b0;
            done_r[head_idx_s]  <= 1'b0;
`ifdef ACTIVE_LIST_EXCEPTION_EN
            exc_r[head_idx_s]   <= 1'b0;
`endif
            head_r              <= head_r + PTR_ONE;
         end
         if (alloc_fire_s) begin
            valid_r[tail_idx_s] <= 1'b1;
            done_r[tail_idx_s]  <= 1'b0;
`ifdef ACTIVE_LIST_EXCEPTION_EN
            exc_r[tail_idx_s]   <= 1'b0;
`endif
            tail_r              <= tail_r + PTR_ONE;
         end
      end
   end

   // Payload storage written on allocation; cleared on reset so the head
   // outputs read zero before anything has been allocated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            dest_r[i] <= '0;
            pc_r[i]   <= '0;
         end
      end else if (alloc_fire_s) begin
         dest_r[tail_idx_s] <= alloc_dest_reg;
         pc_r[tail_idx_s]   <= alloc_pc;
      end else begin
         dest_r[tail_idx_s] <= dest_r[tail_idx_s];
         pc_r[tail_idx_s]   <= pc_r[tail_idx_s];
      end
   end

endmodule

// File: tb/tb_active_list.sv
// Self-checking bench for active_list: a queue-based reference model of the
// in-order list is compared against the DUT on every cycle, plus literal
// expectations at the key points of each directed scenario.
module tb_active_list;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alloc_valid = 1'b0;
   logic        alloc_ready;
   logic [4:0]  alloc_dest_reg = 5'd0;
   logic [31:0] alloc_pc = 32'd0;
   logic [4:0]  alloc_index;
   logic        complete_valid = 1'b0;
   logic [4:0]  complete_index = 5'd0;
   logic        commit_valid;
   logic        commit_ready = 1'b0;
   logic [4:0]  commit_index;
   logic [4:0]  commit_dest_reg;
   logic [31:0] commit_pc;
   logic        flush = 1'b0;
   logic [5:0]  count;
   logic        empty;
   logic        full;
`ifdef ACTIVE_LIST_EXCEPTION_EN
   logic        complete_exception = 1'b0;
   logic        commit_exception;
`endif

   int errors = 0;
   int checks = 0;

   active_list #(.DEPTH(32), .IDX_W(5), .PC_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_dest_reg(alloc_dest_reg), .alloc_pc(alloc_pc), .alloc_index(alloc_index),
      .complete_valid(complete_valid), .complete_index(complete_index),
`ifdef ACTIVE_LIST_EXCEPTION_EN
      .complete_exception(complete_exception), .commit_exception(commit_exception),
`endif
      .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_index(commit_index),
      .commit_dest_reg(commit_dest_reg), .commit_pc(commit_pc),
      .flush(flush), .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   // Reference model: program-ordered queue of in-flight instructions.
   typedef struct {
      int          idx;
      logic [4:0]  dest;
      logic [31:0] pc;
      bit          done;
      bit          exc;
   } ent_t;

   ent_t q[$];
   int   tail_seq = 0;   // allocations since last clear, modulo 2*DEPTH

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit fire_commit;
      bit fire_alloc;
      bit exc_hit;
      bit cexc;
      ent_t e;
`ifdef ACTIVE_LIST_EXCEPTION_EN
      cexc = complete_exception;
`else
      cexc = 1'b0;
`endif
      if (flush) begin
         q.delete();
         tail_seq = 0;
         return;
      end
      fire_commit = (q.size() > 0) && q[0].done && commit_ready;
      exc_hit     = fire_commit && q[0].exc;
      fire_alloc  = alloc_valid && (q.size() < 32);
      if (complete_valid) begin
         foreach (q[i]) begin
            if (q[i].idx == int'(complete_index)) begin
               q[i].done = 1'b1;
               q[i].exc  = q[i].exc | cexc;
            end
         end
      end
      if (fire_commit) void'(q.pop_front());
      if (exc_hit) begin
         q.delete();
         tail_seq = 0;
         return;
      end
      if (fire_alloc) begin
         e.idx  = tail_seq % 32;
         e.dest = alloc_dest_reg;
         e.pc   = alloc_pc;
         e.done = 1'b0;
         e.exc  = 1'b0;
         q.push_back(e);
         tail_seq = (tail_seq + 1) % 64;
      end
   endtask

   task automatic compare();
      bit mv;
      int hidx;
      mv   = (q.size() > 0) && q[0].done;
      hidx = (q.size() > 0) ? q[0].idx : (tail_seq % 32);
      chk("m_alloc_ready", 32'(alloc_ready), 32'(q.size() < 32));
      chk("m_alloc_index", 32'(alloc_index), 32'(tail_seq % 32));
      chk("m_commit_valid", 32'(commit_valid), 32'(mv));
      chk("m_commit_index", 32'(commit_index), 32'(hidx));
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_full", 32'(full), 32'(q.size() == 32));
      if (mv) begin
         chk("m_commit_pc", commit_pc, q[0].pc);
         chk("m_commit_dest", 32'(commit_dest_reg), 32'(q[0].dest));
      end
`ifdef ACTIVE_LIST_EXCEPTION_EN
      chk("m_commit_exc", 32'(commit_exception), 32'(mv && q[0].exc));
`endif
   endtask

   // One clock: model and DUT update on the rising edge, compare on the falling one.
   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic do_alloc(input logic [31:0] pc, input logic [4:0] dst);
      alloc_valid = 1'b1; alloc_pc = pc; alloc_dest_reg = dst;
      step();
      alloc_valid = 1'b0;
   endtask

   task automatic do_complete(input int idx);
      complete_valid = 1'b1; complete_index = 5'(idx);
      step();
      complete_valid = 1'b0;
   endtask

   initial begin
      // Reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("rst_alloc_index", 32'(alloc_index), 32'd0);
      chk("rst_commit_valid", 32'(commit_valid), 32'd0);
      chk("rst_commit_index", 32'(commit_index), 32'd0);
      chk("rst_commit_dest", 32'(commit_dest_reg), 32'd0);
      chk("rst_commit_pc", commit_pc, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      rst_n = 1'b1;

      // Three allocations
      for (int i = 0; i < 3; i++) begin
         chk("alloc_idx", 32'(alloc_index), 32'(i));
         do_alloc(32'h100 + 32'(4 * i), 5'(i + 1));
      end
      chk("count3", 32'(count), 32'd3);
      chk("cv_after_alloc", 32'(commit_valid), 32'd0);

      // Out-of-order completion, in-order commit
      do_complete(1);
      chk("cv_idx1_only", 32'(commit_valid), 32'd0);
      do_complete(0);
      chk("cv_idx0_done", 32'(commit_valid), 32'd1);
      chk("commit_pc0", commit_pc, 32'h100);
      commit_ready = 1'b1;
      step();
      chk("commit_pc1", commit_pc, 32'h104);
      step();
      commit_ready = 1'b0;
      chk("cv_idx2", 32'(commit_valid), 32'd0);
      chk("ci_idx2", 32'(commit_index), 32'd2);

      // Grow to count 7, make head committable, then flush with everything asserted
      for (int i = 0; i < 6; i++) do_alloc(32'h180 + 32'(4 * i), 5'(i + 10));
      do_complete(2);
      chk("count7", 32'(count), 32'd7);
      chk("cv_pre_flush", 32'(commit_valid), 32'd1);
      flush = 1'b1; alloc_valid = 1'b1; complete_valid = 1'b1; complete_index = 5'd3;
      commit_ready = 1'b1;
      step();
      flush = 1'b0; alloc_valid = 1'b0; complete_valid = 1'b0; commit_ready = 1'b0;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_alloc_index", 32'(alloc_index), 32'd0);
      chk("flush_cv", 32'(commit_valid), 32'd0);

      // Completion to unallocated index 9 is ignored
      do_alloc(32'h200, 5'd1);
      do_alloc(32'h204, 5'd2);
      do_complete(9);
      chk("ign_count", 32'(count), 32'd2);
      chk("ign_cv", 32'(commit_valid), 32'd0);

      // Fill to full; 33rd allocation is refused
      for (int i = 2; i < 32; i++) do_alloc(32'h200 + 32'(4 * i), 5'(i));
      chk("full_flag", 32'(full), 32'd1);
      chk("full_ready", 32'(alloc_ready), 32'd0);
      chk("full_count", 32'(count), 32'd32);
      do_alloc(32'hDEAD, 5'd31);
      chk("full_count_33", 32'(count), 32'd32);

      // One commit frees index 0 for the next lap
      do_complete(0);
      commit_ready = 1'b1;
      step();
      commit_ready = 1'b0;
      chk("wrap_count", 32'(count), 32'd31);
      chk("wrap_full", 32'(full), 32'd0);
      chk("wrap_alloc_index", 32'(alloc_index), 32'd0);
      do_alloc(32'h300, 5'd7);
      chk("wrap_full2", 32'(full), 32'd1);
      chk("wrap_count2", 32'(count), 32'd32);

      // Retire up to index 9, which must not be marked done
      for (int i = 1; i < 9; i++) do_complete(i);
      commit_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      commit_ready = 1'b0;
      chk("idx9_head", 32'(commit_index), 32'd9);
      chk("idx9_cv", 32'(commit_valid), 32'd0);
      chk("idx9_count", 32'(count), 32'd24);

      // Drain to count 5, then simultaneous allocate and commit
      for (int i = 9; i < 32; i++) do_complete(i);
      commit_ready = 1'b1;
      for (int i = 0; i < 19; i++) step();
      commit_ready = 1'b0;
      chk("sim_pre_count", 32'(count), 32'd5);
      chk("sim_pre_alloc_index", 32'(alloc_index), 32'd1);
      alloc_valid = 1'b1; alloc_pc = 32'h400; alloc_dest_reg = 5'd3; commit_ready = 1'b1;
      step();
      alloc_valid = 1'b0; commit_ready = 1'b0;
      chk("sim_count", 32'(count), 32'd5);
      chk("sim_head", 32'(commit_index), 32'd29);
      chk("sim_tail", 32'(alloc_index), 32'd2);

`ifdef ACTIVE_LIST_EXCEPTION_EN
      // Excepting head commit discards the whole list
      flush = 1'b1;
      step();
      flush = 1'b0;
      do_alloc(32'h500, 5'd4);
      do_alloc(32'h504, 5'd5);
      complete_exception = 1'b1;
      do_complete(0);
      complete_exception = 1'b0;
      chk("exc_flag", 32'(commit_exception), 32'd1);
      commit_ready = 1'b1;
      step();
      commit_ready = 1'b0;
      chk("exc_count", 32'(count), 32'd0);
      chk("exc_empty", 32'(empty), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
